// File: rtl/addsub_sat_seq_if.sv
// Handshake and data bundle for addsub_sat_seq.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface addsub_sat_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             neg;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, ovf, neg, zero, acc
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, ovf, neg, zero, acc
  );
endinterface

// File: rtl/addsub_sat_seq.sv
// Multi-cycle signed add/subtract with optional saturation and an accumulator.
// A single CHUNK-wide adder slice is reused N times per operation, LSB chunk first.
module addsub_sat_seq #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter bit SATURATE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  addsub_sat_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_q, y_q, sum_q, sum_d, res_d;
  logic signed [WIDTH-1:0] result_q, acc_q;
  logic                    sub_q, acc_op_q, carry_q;
  logic [KW-1:0]           k_q;
  logic                    ovf_q, neg_q, zero_q;
  logic [CHUNK-1:0]        xc, yc;
  logic [CHUNK:0]          ext;
  logic                    last, c_msb, ovf_d;
  logic [31:0]             base;

  function automatic logic signed [WIDTH-1:0] sat_clamp(
    input logic signed [WIDTH-1:0] wrapped,
    input logic                    ovf,
    input logic                    x_sign
  );
    if (SATURATE && ovf)
      return x_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return wrapped;
  endfunction

  // Chunk adder: the MSB carry-in is recovered from the sum bit, so CHUNK=1 needs no special case
  always_comb begin
    last  = (k_q == KW'(N - 1));
    base  = 32'(k_q) * CHUNK;
    xc    = x_q[base +: CHUNK];
    yc    = y_q[base +: CHUNK] ^ {CHUNK{sub_q}};
    ext   = {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, carry_q};
    c_msb = ext[CHUNK-1] ^ xc[CHUNK-1] ^ yc[CHUNK-1];
    ovf_d = c_msb ^ ext[CHUNK];
    sum_d = sum_q;
    sum_d[base +: CHUNK] = ext[CHUNK-1:0];
    res_d = sat_clamp(sum_d, ovf_d, x_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CALC && last) begin
        result_q <= res_d;
        ovf_q    <= ovf_d;
        neg_q    <= res_d[WIDTH-1];
        zero_q   <= (res_d == '0);
        if (acc_op_q)
          acc_q <= res_d;
      end
    end
  end

  // Operand capture and chunk walk; these are always reloaded on accept so they need no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) begin
      x_q      <= bus.op[1] ? acc_q : bus.a;
      y_q      <= bus.op[1] ? bus.a : bus.b;
      sub_q    <= bus.op[0];
      carry_q  <= bus.op[0];
      acc_op_q <= bus.op[1];
      k_q      <= '0;
    end else if (state_q == CALC) begin
      sum_q   <= sum_d;
      carry_q <= ext[CHUNK];
      k_q     <= k_q + KW'(1);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.neg       = neg_q;
  assign bus.zero      = zero_q;
  assign bus.acc       = acc_q;
endmodule

// File: tb/tb_addsub_sat_seq.sv
// Directed bench for addsub_sat_seq: 16-bit saturating/wrapping pair, 8-bit chunk variants,
// and a 32-bit bit-serial instance checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_addsub_sat_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  addsub_sat_seq_if #(.WIDTH(16)) if0 (), if1 ();
  addsub_sat_seq_if #(.WIDTH(8))  if2 (), if3 ();
  addsub_sat_seq_if #(.WIDTH(32)) if4 ();

  // The wrapping 16-bit unit and the CHUNK=8 unit mirror their siblings' inputs
  assign if1.in_valid  = if0.in_valid;
  assign if1.a         = if0.a;
  assign if1.b         = if0.b;
  assign if1.op        = if0.op;
  assign if1.out_ready = if0.out_ready;
  assign if3.in_valid  = if2.in_valid;
  assign if3.a         = if2.a;
  assign if3.b         = if2.b;
  assign if3.op        = if2.op;
  assign if3.out_ready = if2.out_ready;

  addsub_sat_seq #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b1)) u_sat16  (.clk(clk), .rst(rst), .bus(if0));
  addsub_sat_seq #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b0)) u_wrap16 (.clk(clk), .rst(rst), .bus(if1));
  addsub_sat_seq #(.WIDTH(8),  .CHUNK(2), .SATURATE(1'b1)) u_c2     (.clk(clk), .rst(rst), .bus(if2));
  addsub_sat_seq #(.WIDTH(8),  .CHUNK(8), .SATURATE(1'b1)) u_c8     (.clk(clk), .rst(rst), .bus(if3));
  addsub_sat_seq #(.WIDTH(32), .CHUNK(1), .SATURATE(1'b1)) u_w32    (.clk(clk), .rst(rst), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_sat, input logic [15:0] exp_wrap,
                       input logic exp_ovf, input bit chk_wrap, input string tag);
    int lat;
    @(negedge clk);
    if0.in_valid = 1'b1; if0.a = a; if0.b = b; if0.op = op; if0.out_ready = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    if0.in_valid = 1'b0; if0.a = ~a; if0.b = ~b; if0.op = ~op;
    chk({tag, ".in_ready_calc"}, 32'(if0.in_ready), 32'd0);
    lat = 0;
    while (!if0.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".result"},  32'(if0.result), 32'(exp_sat));
    chk({tag, ".ovf"},     32'(if0.ovf), 32'(exp_ovf));
    chk({tag, ".neg"},     32'(if0.neg), 32'(exp_sat[15]));
    chk({tag, ".zero"},    32'(if0.zero), 32'(exp_sat == 16'h0000));
    if (chk_wrap) begin
      chk({tag, ".w.valid"},  32'(if1.out_valid), 32'd1);
      chk({tag, ".w.result"}, 32'(if1.result), 32'(exp_wrap));
      chk({tag, ".w.ovf"},    32'(if1.ovf), 32'(exp_ovf));
      chk({tag, ".w.neg"},    32'(if1.neg), 32'(exp_wrap[15]));
      chk({tag, ".w.zero"},   32'(if1.zero), 32'(exp_wrap == 16'h0000));
    end
    @(negedge clk);
    chk({tag, ".consumed"},    32'(if0.out_valid), 32'd0);
    chk({tag, ".ready_again"}, 32'(if0.in_ready), 32'd1);
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input logic exp_ovf, input string tag);
    int lat2 = -1;
    int lat3 = -1;
    @(negedge clk);
    if2.in_valid = 1'b1; if2.a = a; if2.b = b; if2.op = op; if2.out_ready = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0;
    for (int c = 1; c <= 20 && (lat2 < 0 || lat3 < 0); c++) begin
      @(negedge clk);
      if (lat2 < 0 && if2.out_valid) begin
        lat2 = c;
        chk({tag, ".c2.result"}, 32'(if2.result), 32'(exp));
        chk({tag, ".c2.ovf"},    32'(if2.ovf), 32'(exp_ovf));
      end
      if (lat3 < 0 && if3.out_valid) begin
        lat3 = c;
        chk({tag, ".c8.result"}, 32'(if3.result), 32'(exp));
        chk({tag, ".c8.ovf"},    32'(if3.ovf), 32'(exp_ovf));
      end
    end
    chk({tag, ".c2.latency"}, 32'(lat2), 32'd4);
    chk({tag, ".c8.latency"}, 32'(lat3), 32'd1);
    @(negedge clk);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic op0,
                       input string tag);
    longint r;
    logic [31:0] e;
    logic eo;
    int lat;
    r  = op0 ? (longint'($signed(a)) - longint'($signed(b)))
             : (longint'($signed(a)) + longint'($signed(b)));
    eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e  = eo ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : r[31:0];
    @(negedge clk);
    if4.in_valid = 1'b1; if4.a = a; if4.b = b; if4.op = {1'b0, op0}; if4.out_ready = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    lat = 0;
    while (!if4.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd32);
    chk({tag, ".result"},  if4.result, e);
    chk({tag, ".ovf"},     32'(if4.ovf), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit seen;
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.op = '0; if0.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.op = '0; if2.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.op = '0; if4.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready",  32'(if0.in_ready), 32'd1);
    chk("rst.out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst.result",    32'(if0.result), 32'd0);
    chk("rst.ovf",       32'(if0.ovf), 32'd0);
    chk("rst.neg",       32'(if0.neg), 32'd0);
    chk("rst.zero",      32'(if0.zero), 32'd0);
    chk("rst.acc",       32'(if0.acc), 32'd0);

    run16(2'b00, 16'h1234, 16'h0FED, 16'h2221, 16'h2221, 1'b0, 1'b1, "add_basic");
    run16(2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1, "add_ovf");
    run16(2'b01, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run16(2'b01, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 1'b0, 1'b1, "sub_neg");
    run16(2'b01, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, "sub_zero");
    chk("addsub.acc_untouched", 32'(if0.acc), 32'd0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run16(2'b10, 16'h4000, 16'h1111, 16'h4000, 16'h4000, 1'b0, 1'b0, "acc1");
    run16(2'b10, 16'h4000, 16'h2222, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "acc2");
    run16(2'b10, 16'h4000, 16'h3333, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "acc3");
    chk("acc.after_adds", 32'(if0.acc), 32'h7FFF);
    run16(2'b11, 16'h7FFF, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b0, "acc_sub");
    chk("acc.after_sub", 32'(if0.acc), 32'h0000);

    // Backpressure: result must be held while the consumer stalls
    @(negedge clk);
    if0.in_valid = 1'b1; if0.a = 16'h0005; if0.b = 16'h0003; if0.op = 2'b00; if0.out_ready = 1'b0;
    @(negedge clk);
    if0.in_valid = 1'b0;
    lat = 0;
    while (!if0.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      if0.in_valid = i[0]; if0.a = 16'($urandom); if0.b = 16'($urandom); if0.op = 2'(i);
      @(negedge clk);
      chk("bp.valid_held", 32'(if0.out_valid), 32'd1);
      chk("bp.result_held", 32'(if0.result), 32'h0008);
      chk("bp.ovf_held", 32'(if0.ovf), 32'd0);
      chk("bp.zero_held", 32'(if0.zero), 32'd0);
      chk("bp.in_ready_low", 32'(if0.in_ready), 32'd0);
    end
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk("bp.consumed", 32'(if0.out_valid), 32'd0);
    chk("bp.ready_after", 32'(if0.in_ready), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if0.out_valid || !if0.in_ready) seen = 1'b1;
    end
    chk("bp.consumed_once", 32'(seen), 32'd0);
    chk("bp.result_kept", 32'(if0.result), 32'h0008);

    // Reset during the second compute edge of an accumulate
    run16(2'b10, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 1'b0, 1'b0, "acc_pre");
    chk("rstcalc.acc_before", 32'(if0.acc), 32'h0100);
    @(negedge clk);
    if0.in_valid = 1'b1; if0.a = 16'h0100; if0.op = 2'b10; if0.out_ready = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstcalc.in_ready", 32'(if0.in_ready), 32'd1);
    chk("rstcalc.acc", 32'(if0.acc), 32'd0);
    chk("rstcalc.w.acc", 32'(if1.acc), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if0.out_valid) seen = 1'b1;
    end
    chk("rstcalc.no_output", 32'(seen), 32'd0);
    run16(2'b00, 16'h0003, 16'h0004, 16'h0007, 16'h0007, 1'b0, 1'b1, "post_rst");

    run8(2'b00, 8'h7F, 8'h01, 8'h7F, 1'b1, "w8_ovf");
    run8(2'b01, 8'h05, 8'h03, 8'h02, 1'b0, "w8_sub");

    run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "w32_pos_ovf");
    run32(32'h8000_0000, 32'h0000_0001, 1'b1, "w32_neg_ovf");
    run32(32'h0000_0005, 32'h0000_0007, 1'b1, "w32_neg");
    for (int i = 0; i < 16; i++)
      run32($urandom, $urandom, 1'($urandom_range(0, 1)), "w32_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_sat_seq.md
Name: addsub_sat_seq

Overview:
Parametrised, multi-cycle, signed two's-complement add/subtract unit with optional saturation and an internal accumulator.
- Computes CHUNK bits per clock, LSB chunk first, with carry held between cycles. This trades latency for a narrow adder.
- Valid/ready handshake on both input and output, so it can sit between the ALU issue stage and writeback, or stand alone as an accumulate engine.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥ 2.
CHUNK, 4, bits computed per cycle; WIDTH % CHUNK must equal 0. N = WIDTH/CHUNK is the number of compute cycles.
SATURATE, 1, 1 = clamp on signed overflow; 0 = wrapped result (overflow is still flagged).

Ports:
clk  in  1  rising-edge clock, the single clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands/op presented.
in_ready  out  1  unit can accept; high only in IDLE.
a  in  WIDTH  operand A (signed).
b  in  WIDTH  operand B (signed); ignored for op 10/11.
op  in  2  00: A+B; 01: A−B; 10: ACC+A; 11: ACC−A.
out_valid  out  1  result valid; held until consumed.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  final (saturated or wrapped) result.
ovf  out  1  signed overflow occurred.
neg  out  1  result[WIDTH−1].
zero  out  1  result == 0.
acc  out  WIDTH  current accumulator value.

Behaviour:
- Reset (rst=1 at a clock edge): the following are all cleared.
  - State → IDLE.
  - in_ready=1 after reset; out_valid=0.
  - result=0, ovf=0, neg=0, zero=0, acc=0.
  - Any in-flight operation is abandoned with no output and no acc update.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Handshake at edge E0 (in_valid & in_ready): latch the operands and op.
    - Op 00/01: X=a, Y=b.
    - Op 10/11: X=acc, Y=a.
  - Set sub = op[0], carry = sub, chunk index k = 0, then go to CALC.
  - Later changes on a/b/op are ignored until the next IDLE.
- CALC:
  - in_ready=0.
  - Each edge computes X[k] + (Y[k] ^ {CHUNK{sub}}) + carry, stores the chunk sum, and updates carry. On the last chunk, also records the carry into the MSB (c_msb) and the carry out (c_out).
  - After N edges (E1..EN), go to DONE.
- Overflow: ovf = c_msb ^ c_out.
- Saturation (SATURATE=1 and ovf=1):
  - If X[WIDTH−1]=0: result = 0 followed by WIDTH−1 ones (0x7FFF for 16 bits).
  - If X[WIDTH−1]=1: result = 1 followed by WIDTH−1 zeros (0x8000 for 16 bits).
  - The direction follows the sign of X, not op.
- result, ovf, neg and zero are registered at edge EN. out_valid rises at the same edge, i.e. N cycles after acceptance.
- For op 10/11, acc is loaded with the final (saturated/wrapped) result at edge EN. For op 00/01, acc is unchanged.
- DONE:
  - out_valid=1, in_ready=0.
  - result and the flags are held stable while out_valid & !out_ready.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - Result, flags and acc hold their values after consumption.
- Throughput: minimum N+2 cycles per operation (accept edge, N compute edges, consume edge). There is no overlap.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; the producer must hold it.
- rst asserted in any state overrides all other activity on that edge.

Test Plan:
- WIDTH=16, CHUNK=4, op=00, a=0x1234, b=0x0FED, out_ready=1 → out_valid rises 4 cycles after accept; result=0x2221, ovf=0, neg=0, zero=0; in_ready back high on the cycle after consume.
- Saturation corners, each checked with SATURATE=1 and SATURATE=0:
  - op=00, 0x7FFF+0x0001 → 0x7FFF, ovf=1 (SATURATE=0: 0x8000, ovf=1).
  - op=01, 0x8000−0x0001 → 0x8000, ovf=1 (SATURATE=0: 0x7FFF).
  - op=01, 0x0005−0x0007 → 0xFFFE, neg=1, ovf=0.
  - op=01, 0x1234−0x1234 → 0x0000, zero=1.
- Accumulate: three op=10 with a=0x4000 from reset → results 0x4000 (ovf=0), 0x7FFF (ovf=1), 0x7FFF (ovf=1); acc=0x7FFF. Then op=11, a=0x7FFF → 0x0000, zero=1, acc=0x0000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling a/b/in_valid meanwhile → result and flags stable, in_ready=0, no new accept; a single out_ready pulse consumes the result exactly once.
- Reset mid-CALC: assert rst on the 2nd compute edge of an op=10 → out_valid never rises, acc=0, state IDLE with in_ready=1; the next op 0x0003+0x0004 returns 0x0007.
- Parameter sweep:
  - WIDTH=8, CHUNK=2: 0x7F+0x01 → 0x7F, ovf=1, latency 4.
  - WIDTH=8, CHUNK=8: latency 1.
  - WIDTH=32, CHUNK=1: random signed add/sub checked against a saturating reference model, latency 32.
